lod_pipe_scheduler: RTL and testbench

//  Sequences a batch of output-buffer words through the LOD -> shift -> constant_multipler datapath and writes the results back.

---
 rtl/lod_pipe_scheduler_pkg.sv | 7 +
 rtl/lod_pipe_scheduler_fifo.sv | 36 +++
 rtl/lod_pipe_scheduler.sv | 91 +++++++++
 tb/tb_lod_pipe_scheduler.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/lod_pipe_scheduler_pkg.sv
// lod_pipe_scheduler_pkg: shared widths, pipe latencies and FSM encoding for the LOD pipe scheduler
package lod_pipe_scheduler_pkg;
  localparam int OUTPUT_BUF_DATASIZE = 32;
  localparam int LOD_PIPE_LAT = 2;
  localparam int LOD_FIFO_DEPTH = 4;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/lod_pipe_scheduler_fifo.sv
// lod_result_fifo: synchronous result FIFO with occupancy count; DEPTH must be a power of two
module lod_result_fifo import lod_pipe_scheduler_pkg::*; #(
  parameter int DATA_W = OUTPUT_BUF_DATASIZE,
  parameter int DEPTH = LOD_FIFO_DEPTH,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [CW-1:0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign dout = empty ? '0 : mem[rptr];
  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/lod_pipe_scheduler.sv
// lod_pipe_scheduler: streams a buffer batch through the LOD/shift/multiplier pipe and writes results back
module lod_pipe_scheduler import lod_pipe_scheduler_pkg::*; #(
  parameter int DATA_W = OUTPUT_BUF_DATASIZE,
  parameter int ADDR_W = 8,
  parameter int PIPE_LAT = LOD_PIPE_LAT,
  parameter int RD_LAT = 1,
  parameter int FIFO_DEPTH = LOD_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] dp_in,
  output logic [DATA_W-1:0] dp_in_dly,
  input  logic [DATA_W-1:0] dp_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready
);
  localparam int VPD = RD_LAT + 1 + PIPE_LAT;
  localparam int CW = $clog2(FIFO_DEPTH + VPD + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] base, len_q;
  logic [ADDR_W:0] issue_cnt, wr_cnt;
  logic [VPD-1:0] vpipe;
  logic [CW-1:0] inflight;
  logic [FCW-1:0] fifo_count;
  logic fifo_empty, fifo_full, fifo_push, pop, credit, accept;
  assign accept = state == S_IDLE && start;
  assign fifo_push = vpipe[VPD-1];
  assign pop = wr_en && wr_ready;
  // every issued read reserves a FIFO slot until its result is popped
  assign credit = inflight + CW'(fifo_count) < CW'(FIFO_DEPTH) && !fifo_full;
  assign wr_en = !fifo_empty;
  assign rd_addr = base + issue_cnt[ADDR_W-1:0];
  assign wr_addr = base + wr_cnt[ADDR_W-1:0];
  always_ff @(posedge clk)
    state <= rst ? S_IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = (length == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (rd_en && issue_cnt + (ADDR_W+1)'(1) == {1'b0, len_q}) state_nxt = S_DRAIN;
      S_DRAIN: if (pop && wr_cnt + (ADDR_W+1)'(1) == {1'b0, len_q}) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
    endcase
  end
  always_comb begin
    busy = state == S_ISSUE || state == S_DRAIN;
    done = state == S_DONE;
    rd_en = state == S_ISSUE && credit;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      base <= '0;
      len_q <= '0;
      issue_cnt <= '0;
      wr_cnt <= '0;
      vpipe <= '0;
      inflight <= '0;
      dp_in <= '0;
      dp_in_dly <= '0;
    end else begin
      vpipe <= {vpipe[VPD-2:0], rd_en};
      inflight <= inflight + CW'(rd_en) - CW'(fifo_push);
      dp_in <= vpipe[RD_LAT-1] ? rd_data : '0;
      dp_in_dly <= dp_in;
      if (accept) begin
        base <= base_addr;
        len_q <= length;
        issue_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        if (rd_en) issue_cnt <= issue_cnt + (ADDR_W+1)'(1);
        if (pop) wr_cnt <= wr_cnt + (ADDR_W+1)'(1);
      end
    end
  end
  lod_result_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH), .CW(FCW)) u_fifo (
    .clk(clk), .rst(rst), .push(fifo_push), .pop(pop), .din(dp_out),
    .dout(wr_data), .empty(fifo_empty), .full(fifo_full), .count(fifo_count)
  );
endmodule

// File: tb/tb_lod_pipe_scheduler.sv
// tb_lod_pipe_scheduler: buffer + datapath model around the scheduler, scoreboarded write-back checks
module tb_lod_pipe_scheduler;
  logic clk = 0, rst = 1, start = 0, wr_ready = 1;
  logic [7:0] base_addr = 0, length = 0;
  logic busy, done, rd_en, wr_en;
  logic [7:0] rd_addr, wr_addr;
  logic [31:0] rd_data = 0, dp_in, dp_in_dly, dp_out, wr_data;
  logic [31:0] mem [256];
  logic [4:0] lod_r = 0;
  logic [31:0] sh_r = 0;
  typedef struct {logic [7:0] addr; logic [31:0] data;} exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0, cyc = 0;
  int rd_count = 0, wr_count = 0, done_count = 0;
  bit ovf_seen = 0;

  lod_pipe_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .dp_in(dp_in), .dp_in_dly(dp_in_dly), .dp_out(dp_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] lod(input logic [31:0] x);
    lod = 0;
    for (int i = 0; i < 32; i++) if (x[i]) lod = 5'(i);
  endfunction

  function automatic logic [31:0] ref_f(input logic [31:0] x);
    return (x << (5'd31 - lod(x))) * 32'd3;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // buffer with 1-cycle read latency, LOD reg, shift reg, combinational multiplier
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= mem[rd_addr];
    lod_r <= lod(dp_in);
    sh_r <= dp_in_dly << (5'd31 - lod_r);
  end
  assign dp_out = sh_r * 32'd3;

  always @(negedge clk) begin
    if (dut.fifo_push && dut.u_fifo.full) ovf_seen = 1;
    if (!rst) begin
      if (rd_en) rd_count++;
      if (done) done_count++;
      if (wr_en && wr_ready) begin
        wr_count++;
        if (exp_q.size() == 0) check("sb_extra_write", {24'h0, wr_addr, wr_data}, 64'h0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
        end
      end
    end
  end

  task automatic fill(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++)
      mem[b + 8'(i)] = (i == 0) ? 32'h8000_0000 : (i == 1) ? 32'h0 : (i == 2) ? 32'h1 : $urandom;
  endtask

  task automatic run_job(input logic [7:0] b, input logic [7:0] n, input int hold,
                         output int lat, output int done_gap, output int done_lat,
                         output int nrd, output int nwr, output int nheld, output logic busy1);
    int s, first, last, dc, rd0, wr0;
    logic [7:0] a;
    for (int i = 0; i < int'(n); i++) begin
      a = b + 8'(i);
      exp_q.push_back('{addr: a, data: ref_f(mem[a])});
    end
    @(posedge clk); #1;
    rd0 = rd_count; wr0 = wr_count;
    start = 1; base_addr = b; length = n; wr_ready = (hold == 0); s = cyc;
    first = -1; last = -1; dc = -1; nheld = 0; busy1 = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      start = 0;
      if (k == 0) busy1 = busy;
      if (hold > 0 && cyc - s >= hold) wr_ready = 1;
      if (rd_en && !wr_ready) nheld++;
      if (wr_en && wr_ready) begin
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (done) begin
        dc = cyc;
        break;
      end
    end
    check("job_done_seen", dc >= 0, 1);
    lat = first - s; done_gap = dc - last; done_lat = dc - s;
    nrd = rd_count - rd0; nwr = wr_count - wr0;
  endtask

  initial begin
    int lat, dg, dl, nrd, nwr, nh, n_is, d0;
    logic b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {busy, done, rd_en, wr_en}, 4'b0);
    check("rst_addr", {rd_addr, wr_addr}, 16'h0);
    check("rst_data", {dp_in, wr_data}, 64'h0);
    rst = 0;

    mem[8'h10] = 32'b00010000000100000110100000001000;
    run_job(8'h10, 8'd1, 0, lat, dg, dl, nrd, nwr, nh, b1);
    check("t1_latency", lat, 6);
    check("t1_done_after_write", dg, 1);
    check("t1_writes", nwr, 1);
    check("t1_busy", b1, 1);

    fill(8'h00, 8);
    run_job(8'h00, 8'd8, 0, lat, dg, dl, nrd, nwr, nh, b1);
    check("t2_reads", nrd, 8);
    check("t2_writes", nwr, 8);
    check("t2_done_after_write", dg, 1);
    @(posedge clk); #1;
    check("t2_busy_after_done", {busy, done}, 2'b00);

    fill(8'h30, 8);
    run_job(8'h30, 8'd8, 20, lat, dg, dl, nrd, nwr, nh, b1);
    check("t3_reads_before_stall", nh, 4);
    check("t3_reads", nrd, 8);
    check("t3_writes", nwr, 8);
    check("t3_no_overflow", ovf_seen, 0);

    d0 = done_count;
    run_job(8'h50, 8'd0, 0, lat, dg, dl, nrd, nwr, nh, b1);
    check("t4_done_latency", dl, 1);
    check("t4_reads", nrd, 0);
    check("t4_writes", nwr, 0);
    check("t4_done_pulses", done_count - d0, 1);

    fill(8'h40, 8);
    @(posedge clk); #1;
    start = 1; base_addr = 8'h40; length = 8'd8; wr_ready = 1;
    @(posedge clk); #1;
    start = 0; n_is = 0;
    for (int k = 0; k < 20 && !rst; k++) begin
      if (rd_en) begin
        n_is++;
        if (n_is == 2) begin start = 1; base_addr = 8'h80; length = 8'd3; end
        if (n_is == 3) begin
          check("t5_no_relatch", rd_addr, 8'h42);
          rst = 1;
        end
      end
      @(posedge clk); #1;
      start = 0;
    end
    check("t5_rst_at_issue3", n_is, 3);
    check("t5_rst_ctrl", {busy, done, rd_en, wr_en}, 4'b0);
    check("t5_rst_addr", {rd_addr, wr_addr}, 16'h0);
    check("t5_rst_data", {dp_in, wr_data}, 64'h0);
    rst = 0;
    d0 = done_count;
    repeat (12) @(posedge clk);
    #1;
    check("t5_no_done", done_count - d0, 0);
    fill(8'h20, 5);
    run_job(8'h20, 8'd5, 0, lat, dg, dl, nrd, nwr, nh, b1);
    check("t5_clean_writes", nwr, 5);
    check("t5_clean_latency", lat, 6);

    fill(8'hFE, 4);
    run_job(8'hFE, 8'd4, 0, lat, dg, dl, nrd, nwr, nh, b1);
    check("t6_writes", nwr, 4);
    check("t6_reads", nrd, 4);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", exp_q.size(), 0);
    check("no_overflow", ovf_seen, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end
endmodule
